// File: rtl/param_seq_detector.sv
// param_seq_detector: KMP-style Moore detector for a configurable serial pattern,
// with selectable overlap and a saturating match counter.
module param_seq_detector #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1100,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_seq,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             det_out,
  output logic [CNT_W-1:0] det_count
);
  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int NS = 2 ** SW;
  function automatic bit pat(input int i);
    return PATTERN[PAT_LEN-1-i];
  endfunction
  // Longest pattern prefix that is a suffix of (first k pattern bits + b).
  function automatic int delta(input int k, input int b);
    int r;
    bit ok;
    bit sb;
    r = 0;
    for (int j = k + 1; j >= 1; j--) begin
      if (r == 0) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          sb = (k + 1 - j + t < k) ? pat(k + 1 - j + t) : bit'(b);
          if (sb != pat(t)) ok = 1'b0;
        end
        if (ok) r = j;
      end
    end
    return r;
  endfunction
  function automatic int border();
    int r;
    bit ok;
    r = 0;
    for (int j = PAT_LEN - 1; j >= 1; j--) begin
      if (r == 0) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++)
          if (pat(t) != pat(PAT_LEN - j + t)) ok = 1'b0;
        if (ok) r = j;
      end
    end
    return r;
  endfunction
  localparam logic [SW-1:0] FULL = SW'(PAT_LEN);
  localparam logic [SW-1:0] BORDER = SW'(border());
  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad
    $error("PAT_LEN must be in 2..16");
  end
  logic [SW-1:0] tbl [2][NS];
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    for (genvar b = 0; b < 2; b++) begin : g_bit
      if (k < PAT_LEN) begin : g_live
        assign tbl[b][k] = SW'(delta(k, b));
      end else begin : g_dead
        assign tbl[b][k] = '0;
      end
    end
  end
  logic [SW-1:0] state, cur, nxt;
  always_ff @(posedge clk)
    state <= rst ? '0 : nxt;
  // From the full-match state, resume at the border (overlap) or at zero.
  always_comb begin
    cur = (state == FULL) ? (overlap_en ? BORDER : '0) : state;
    nxt = in_valid ? tbl[in_seq][cur] : state;
  end
  always_comb det_out = (state == FULL);
  always_ff @(posedge clk)
    if (rst || cnt_clr) det_count <= '0;
    else if (in_valid && nxt == FULL && det_count != '1) det_count <= det_count + 1'b1;
endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: directed scoreboard bench over three detector configurations.
module tb_param_seq_detector;
  logic clk = 0, rst = 0, in_valid = 0, in_seq = 0, overlap_en = 1, cnt_clr = 0;
  logic det0, det1, det2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  typedef struct {string tag; int u; logic det; int cnt;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  param_seq_detector u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
    .overlap_en(overlap_en), .cnt_clr(cnt_clr), .det_out(det0), .det_count(cnt0));
  param_seq_detector #(.PATTERN(4'b1010)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_seq(in_seq), .overlap_en(overlap_en), .cnt_clr(cnt_clr), .det_out(det1), .det_count(cnt1));
  param_seq_detector #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_seq(in_seq), .overlap_en(overlap_en), .cnt_clr(cnt_clr), .det_out(det2), .det_count(cnt2));

  always #5 clk = ~clk;

  task automatic check_one();
    exp_t e;
    logic d;
    int c;
    e = sb.pop_front();
    d = (e.u == 0) ? det0 : (e.u == 1) ? det1 : det2;
    c = (e.u == 0) ? int'(cnt0) : (e.u == 1) ? int'(cnt1) : int'(cnt2);
    checks++;
    assert (d === e.det) else begin
      errors++;
      $error("FAIL %s det_out got %b want %b", e.tag, d, e.det);
    end
    checks++;
    assert (c === e.cnt) else begin
      errors++;
      $error("FAIL %s det_count got %0d want %0d", e.tag, c, e.cnt);
    end
  endtask

  task automatic step(input int u, input logic v, input logic b, input logic ov, input logic clr,
                      input logic ed, input int ec, input string tag);
    in_valid = v; in_seq = b; overlap_en = ov; cnt_clr = clr;
    sb.push_back('{tag, u, ed, ec});
    @(posedge clk); #1;
    check_one();
  endtask

  task automatic do_reset(input int u, input string tag);
    rst = 1; in_valid = 1; in_seq = 0; cnt_clr = 0;
    sb.push_back('{tag, u, 1'b0, 0});
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    check_one();
  endtask

  task automatic run(input int u, input logic ov, input string bits, input string dets,
                     input string cnts, input string tag);
    for (int i = 0; i < bits.len(); i++)
      step(u, 1'b1, bits[i] == "1", ov, 1'b0, dets[i] == "1", int'(cnts[i]) - 48,
           $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    do_reset(0, "rst_a");
    run(0, 1'b1, "11001", "00010", "00011", "basic");
    do_reset(0, "rst_b");
    run(0, 1'b1, "11100", "00001", "00001", "prefix111");
    do_reset(1, "rst_c");
    run(1, 1'b1, "101010", "000101", "000112", "ovl_on");
    do_reset(1, "rst_d");
    run(1, 1'b0, "101010", "000100", "000111", "ovl_off");
    run(1, 1'b0, "10", "01", "12", "ovl_off_app");
    do_reset(0, "rst_e");
    run(0, 1'b1, "110", "000", "000", "stall_pre");
    for (int i = 0; i < 5; i++) step(0, 1'b0, i[0], 1'b1, 1'b0, 1'b0, 0, "stall");
    run(0, 1'b1, "0", "1", "1", "stall_post");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, "det_hold0");
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, "det_hold1");
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, "leave_nov");
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "clr_idle");
    run(0, 1'b0, "100", "001", "001", "after_clr");
    do_reset(0, "rst_f");
    run(0, 1'b1, "110", "000", "000", "mid_pre");
    do_reset(0, "mid_rst");
    run(0, 1'b1, "0", "0", "0", "mid_post");
    run(0, 1'b1, "1100", "0001", "0001", "mid_again");
    do_reset(2, "rst_g");
    for (int g = 0; g < 5; g++)
      for (int i = 0; i < 4; i++)
        step(2, 1'b1, i < 2, 1'b1, 1'b0, i == 3,
             (i == 3) ? ((g + 1 > 3) ? 3 : g + 1) : ((g > 3) ? 3 : g), "sat");
    run(2, 1'b1, "110", "000", "333", "sat_hold");
    step(2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, "clr_vs_det");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
